// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the 32x32 register file: round-robin arbitration of
// producer write-backs onto the single write port, plus a per-register busy
// scoreboard for RAW/WAW hazard detection at decode.
module regfile_wb_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [AW*N_REQ-1:0]   req_addr,
    input  logic [DW*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  alloc_valid,
    input  logic [AW-1:0]         alloc_addr,
    input  logic [AW-1:0]         rs_q,
    input  logic [AW-1:0]         rt_q,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic                  waw_err,
    output logic                  w_ena,
    output logic [AW-1:0]         Rdc,
    output logic [DW-1:0]         Rd
);

    localparam int unsigned PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NREG = 1 << AW;

    logic [PW-1:0]    r_rr_ptr;
    logic [NREG-1:0]  r_busy;
    logic             r_waw;
    logic             r_wena;
    logic [AW-1:0]    r_rdc;
    logic [DW-1:0]    r_rd;

    logic [N_REQ-1:0] w_grant;
    logic [PW-1:0]    w_gnt_idx;
    logic             w_xfer;
    logic [31:0]      w_idx;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_data;
    logic [NREG-1:0]  w_clr;
    logic [NREG-1:0]  w_set;
    logic [NREG-1:0]  w_busy_nxt;
    logic             w_waw;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = r_rr_ptr;
        w_xfer    = 1'b0;
        w_idx     = '0;
        if (ena) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                w_idx = (32'(r_rr_ptr) + 32'(k)) % 32'(N_REQ);
                if (!w_xfer && req_valid[w_idx[PW-1:0]]) begin
                    w_xfer                 = 1'b1;
                    w_gnt_idx              = w_idx[PW-1:0];
                    w_grant[w_idx[PW-1:0]] = 1'b1;
                end
            end
        end
    end

    assign w_sel_addr = req_addr[AW*w_gnt_idx +: AW];
    assign w_sel_data = req_data[DW*w_gnt_idx +: DW];

    // Scoreboard next state: clear on completing write, set on alloc (set wins)
    always_comb begin
        w_clr = '0;
        w_set = '0;
        if (r_wena) begin
            w_clr[r_rdc] = 1'b1;
        end
        if (alloc_valid && (alloc_addr != '0)) begin
            w_set[alloc_addr] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    assign w_waw = alloc_valid && (alloc_addr != '0) && r_busy[alloc_addr] && !w_clr[alloc_addr];

    // Arbitration pointer and scoreboard state, frozen while ena is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= PW'(N_REQ - 1);
            r_busy   <= '0;
            r_waw    <= 1'b0;
        end else if (ena) begin
            if (w_xfer) begin
                r_rr_ptr <= w_gnt_idx;
            end
            r_busy <= w_busy_nxt;
            r_waw  <= w_waw;
        end
    end

    // Output stage toward the register file; address 0 is consumed without a write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wena <= 1'b0;
            r_rdc  <= '0;
            r_rd   <= '0;
        end else if (w_xfer) begin
            r_wena <= (w_sel_addr != '0);
            r_rdc  <= w_sel_addr;
            r_rd   <= w_sel_data;
        end else begin
            r_wena <= 1'b0;
        end
    end

    assign req_ready = w_grant;
    assign rs_busy   = r_busy[rs_q];
    assign rt_busy   = r_busy[rt_q];
    assign waw_err   = r_waw;
    assign w_ena     = r_wena;
    assign Rdc       = r_rdc;
    assign Rd        = r_rd;

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
Write-back scheduler for the 32x32 register file. It arbitrates write-back requests from several producers (ALU, load path, HI/LO and CP0 moves, multi-cycle mult/div) onto the register file's single write port (w_ena/Rdc/Rd). It also keeps a per-register busy scoreboard so decode can stall on RAW hazards against in-flight producers. It sits between the execute-side producers and the register file. It is posedge-clocked; the register file writes on the following negedge.

Parameters:
N_REQ, 4, number of write-back requesters (index 0 = highest initial priority)
AW, 5, register address width
DW, 32, data width

Ports:
clk  input  1  system clock, posedge
rst  input  1  asynchronous, active-low reset
ena  input  1  block enable; low freezes grants, output stage and scoreboard
req_valid  input  N_REQ  per-requester write-back request
req_addr  input  AW*N_REQ  destination register, requester i at [AW*i +: AW]
req_data  input  DW*N_REQ  write data, requester i at [DW*i +: DW]
req_ready  output  N_REQ  one-hot grant, combinational
alloc_valid  input  1  decode reserves a destination register
alloc_addr  input  AW  register being reserved
rs_q  input  AW  source register query A
rt_q  input  AW  source register query B
rs_busy  output  1  busy[rs_q], combinational
rt_busy  output  1  busy[rt_q], combinational
waw_err  output  1  registered one-cycle pulse: alloc to an already-busy register
w_ena  output  1  to register file write enable
Rdc  output  AW  to register file write address
Rd  output  DW  to register file write data

Behaviour:
- Reset (rst=0, async): w_ena=0, Rdc=0, Rd=0, waw_err=0, busy[31:0]=0, rr_ptr=N_REQ-1. With no valid requests, req_ready=0.
- Handshake: a transfer happens at the posedge where req_valid[i] & req_ready[i]. The requester holds valid, addr and data stable until that posedge. At most one grant per cycle. req_ready is all-zero when ena=0.
- Arbitration is round-robin. The search starts at (rr_ptr+1) mod N_REQ and grants the first valid requester found. On each transfer, rr_ptr <= granted index. If there is no transfer, rr_ptr holds. Wrap-around from index N_REQ-1 to 0 is required.
- Output stage (registered, 1-cycle latency):
  - On a transfer: w_ena <= (addr!=0), Rdc <= addr, Rd <= data.
  - Otherwise: w_ena <= 0, and Rdc/Rd hold.
  - The register file captures the write at the negedge of the cycle in which w_ena=1.
- Address 0: the request is granted and consumed, but no write is issued (w_ena stays 0). busy[0] is never set: alloc to 0 is ignored and rs_busy/rt_busy for address 0 is always 0.
- Scoreboard, evaluated at each posedge with ena=1:
  - set: alloc_valid & alloc_addr!=0 sets busy[alloc_addr].
  - clear: w_ena=1 in the ending cycle clears busy[Rdc].
  - Set and clear on the same address in the same edge: set wins.
  - Clears and sets on different addresses both take effect.
- waw_err <= alloc_valid & alloc_addr!=0 & busy[alloc_addr] & ~(clear of the same address this edge). The register stays busy.
- A write-back to a register that is not busy is legal. It writes normally and busy is unchanged.
- ena=0: no grants, and w_ena <= 0 at the next edge. busy, rr_ptr and waw_err hold. rs_busy/rt_busy still reflect busy.
- Reset asserted mid-operation: any pending output-stage write is dropped (w_ena forced 0 immediately). The scoreboard is cleared and arbitration restarts with requester 0 first.
- Throughput: one write-back per cycle when requests are continuous.

Test Plan:
- Reset, then req_valid=4'b1111, each with addr=i+1, data=32'hA0+i, held until granted -> grants in order 0,1,2,3 on consecutive cycles. w_ena=1 with Rdc=1..4 and Rd=A0..A3 one cycle after each grant. rr_ptr ends at 3.
- Requesters 1 and 3 valid continuously, with re-request after each grant -> grants alternate 1,3,1,3. After 3, the wrap-around search grants 1 ahead of 3.
- alloc_valid with alloc_addr=8 -> rs_busy=1 for rs_q=8 next cycle. Requester 2 write-back to r8 -> busy clears at the posedge ending the w_ena cycle. A same-edge alloc of r8 keeps busy=1.
- alloc r5 twice without write-back -> waw_err pulses for exactly one cycle after the second alloc. alloc r0 and write-back to r0 -> no busy set, w_ena=0, the request is still consumed (req_ready pulse).
- Pending grant plus busy[3]=1, then rst pulled low asynchronously mid-cycle -> w_ena=0, busy=0 immediately. After release, requester 0 wins against 0 and 2 both valid.
- ena=0 with requests valid -> req_ready=0, w_ena=0 after one edge, busy held. ena=1 -> arbitration resumes from the saved rr_ptr.
